// File: rtl/ts_pkg.sv
// Shared types, default timing constants and the result-rounding helper for ts_meas_sched.
package ts_pkg;

    localparam int unsigned CLK_DIV_DEF     = 25;
    localparam int unsigned SETTLE_CYC_DEF  = 64;
    localparam int unsigned TIMEOUT_CYC_DEF = 1024;
    localparam int unsigned ACC_W           = 13;
    localparam int unsigned DOUT_W          = 8;
    localparam int unsigned CNT_W           = 16;
    localparam int unsigned PAIR_W          = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        CONV_P,
        CONV_N,
        ACCUM,
        DONE,
        WAIT
    } ts_state_e;

    // Mean of 2^(sel+1) samples, rounded half up and saturated to 8 bits.
    function automatic logic [DOUT_W-1:0] ts_avg(input logic [ACC_W-1:0] acc,
                                                 input logic [1:0]       sel);
        logic [ACC_W:0] sum;
        logic [ACC_W:0] quo;
        sum = {1'b0, acc} + ((ACC_W+1)'(1) << sel);
        quo = sum >> ({1'b0, sel} + 3'd1);
        return (quo > (ACC_W+1)'(255)) ? 8'hFF : quo[DOUT_W-1:0];
    endfunction

endpackage

// File: rtl/ts_detok_sync.sv
// Synchronises the asynchronous DETOK, emits a one-cycle pulse on its rising edge
// and captures DOUT in the same cycle the edge is detected.
module ts_detok_sync
    import ts_pkg::*;
(
    input  logic              clk,
    input  logic              RST,
    input  logic              i_detok,
    input  logic [DOUT_W-1:0] i_dout,
    output logic              o_det_pulse,
    output logic [DOUT_W-1:0] o_sample
);

    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic              r_det_pulse;
    logic [DOUT_W-1:0] r_sample;
    logic              w_rise;

    assign w_rise      = r_s2 & ~r_s3;
    assign o_det_pulse = r_det_pulse;
    assign o_sample    = r_sample;

    // Two-flop synchroniser, edge history, and DOUT capture on the detected edge.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_det_pulse <= 1'b0;
            r_sample    <= '0;
        end else begin
            r_s1        <= i_detok;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_det_pulse <= w_rise;
            if (w_rise) begin
                r_sample <= i_dout;
            end
        end
    end

endmodule

// File: rtl/ts_meas_sched.sv
// Temperature-sensor measurement scheduler: powers the TS macro, runs chopped
// conversion pairs, averages them and hands one 8-bit result out over valid/ready.
module ts_meas_sched
    import ts_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
    parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              FLOCK,
    input  logic              reg_ts_en_sel,
    input  logic              reg_meas_en,
    input  logic [15:0]       reg_meas_period,
    input  logic [1:0]        reg_avg_sel,
    input  logic              A2D_TS_DETOK,
    input  logic [DOUT_W-1:0] A2D_TS_DOUT,
    output logic              D2A_TS_EN,
    output logic              D2A_TS_START_EN,
    output logic              D2A_TS_CLK,
    output logic              D2A_TS_CHOPPER_CLK,
    output logic [DOUT_W-1:0] ts_data,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic              ts_timeout,
    output logic              busy
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    ts_state_e         r_state;
    logic [DIV_W-1:0]  r_div;
    logic              r_half;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [DOUT_W-1:0] r_p;
    logic [PAIR_W-1:0] r_pair;
    logic [1:0]        r_avg_sel;
    logic              r_start_en;
    logic              r_ts_clk;
    logic              r_chop;
    logic [DOUT_W-1:0] r_data;
    logic              r_valid;
    logic              r_timeout;
    logic              r_busy;

    logic              w_tick;
    logic              w_period;
    logic              w_det_pulse;
    logic [DOUT_W-1:0] w_sample;
    logic              w_enabled;
    logic              w_busy_state;

    assign D2A_TS_EN          = reg_ts_en_sel ? FLOCK : 1'b1;
    assign D2A_TS_START_EN    = r_start_en;
    assign D2A_TS_CLK         = r_ts_clk;
    assign D2A_TS_CHOPPER_CLK = r_chop;
    assign ts_data            = r_data;
    assign ts_valid           = r_valid;
    assign ts_timeout         = r_timeout;
    assign busy               = r_busy;

    assign w_tick       = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_period     = w_tick & r_half;
    assign w_enabled    = reg_meas_en & D2A_TS_EN;
    assign w_busy_state = (r_state != IDLE) && (r_state != WAIT);

    ts_detok_sync u_detok_sync (
        .clk        (clk),
        .RST        (RST),
        .i_detok    (A2D_TS_DETOK),
        .i_dout     (A2D_TS_DOUT),
        .o_det_pulse(w_det_pulse),
        .o_sample   (w_sample)
    );

    // Free-running divider; r_half marks every second tick as a full TS period.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_div  <= '0;
            r_half <= 1'b0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_half <= ~r_half;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    // Measurement FSM with its counters, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_p        <= '0;
            r_pair     <= '0;
            r_avg_sel  <= '0;
            r_start_en <= 1'b0;
            r_ts_clk   <= 1'b0;
            r_chop     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // TS clock runs only while a conversion is pending.
            if ((r_state == CONV_P) || (r_state == CONV_N)) begin
                if (w_tick) begin
                    r_ts_clk <= ~r_ts_clk;
                end
            end else begin
                r_ts_clk <= 1'b0;
            end

            if (w_busy_state && !D2A_TS_EN) begin
                // Enable lost: drop everything and flag the aborted measurement.
                r_state    <= IDLE;
                r_cnt      <= '0;
                r_acc      <= '0;
                r_pair     <= '0;
                r_start_en <= 1'b0;
                r_ts_clk   <= 1'b0;
                r_chop     <= 1'b0;
                r_data     <= '0;
                r_valid    <= 1'b0;
                r_timeout  <= 1'b1;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_enabled) begin
                            r_state <= SETTLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (w_period) begin
                            if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                                r_state    <= START;
                                r_cnt      <= '0;
                                r_start_en <= 1'b1;
                                r_chop     <= 1'b1;
                                r_avg_sel  <= reg_avg_sel;
                                r_acc      <= '0;
                                r_pair     <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    START: begin
                        if (w_period) begin
                            r_state    <= CONV_P;
                            r_start_en <= 1'b0;
                        end
                    end
                    CONV_P, CONV_N: begin
                        if (w_det_pulse) begin
                            r_cnt <= '0;
                            if (r_state == CONV_P) begin
                                r_p     <= w_sample;
                                r_chop  <= 1'b0;
                                r_state <= CONV_N;
                            end else begin
                                r_acc    <= r_acc + ACC_W'(r_p) + ACC_W'(w_sample);
                                r_pair   <= r_pair + PAIR_W'(1);
                                r_ts_clk <= 1'b0;
                                r_state  <= ACCUM;
                            end
                        end else if (w_period) begin
                            if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                                r_state   <= WAIT;
                                r_cnt     <= '0;
                                r_acc     <= '0;
                                r_pair    <= '0;
                                r_ts_clk  <= 1'b0;
                                r_chop    <= 1'b0;
                                r_timeout <= 1'b1;
                                r_busy    <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ACCUM: begin
                        if (r_pair == (PAIR_W'(1) << r_avg_sel)) begin
                            r_state   <= DONE;
                            r_data    <= ts_avg(r_acc, r_avg_sel);
                            r_valid   <= 1'b1;
                            r_timeout <= 1'b0;
                        end else begin
                            r_state <= CONV_P;
                            r_chop  <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                    DONE: begin
                        if (ts_ready) begin
                            r_state <= WAIT;
                            r_valid <= 1'b0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if ((reg_meas_period == 16'd0) ||
                            (w_period && (r_cnt == reg_meas_period - 16'd1))) begin
                            r_cnt <= '0;
                            if (w_enabled) begin
                                r_state <= SETTLE;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else if (w_period) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
